// File: rtl/bus_burst_initiator_if.sv
// Signal bundle between a burst initiator and its command/data clients and the memory bus.
// master is the initiator's view; slave is the view of everything around it.
interface bus_burst_initiator_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 4
);

  // Command port
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_rwn;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;

  // Write-data stream
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;

  // Read-data stream
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;

  // Memory bus
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_rwn;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_wdata_oe;
  logic [DATA_W-1:0] bus_rdata;

  logic              done;

  modport master (
    input  cmd_valid, cmd_rwn, cmd_addr, cmd_len,
    input  wr_valid, wr_data,
    input  rd_ready,
    input  bus_rdata,
    output cmd_ready, wr_ready, rd_valid, rd_data,
    output bus_addr, bus_rwn, bus_wdata, bus_wdata_oe,
    output done
  );

  modport slave (
    output cmd_valid, cmd_rwn, cmd_addr, cmd_len,
    output wr_valid, wr_data,
    output rd_ready,
    output bus_rdata,
    input  cmd_ready, wr_ready, rd_valid, rd_data,
    input  bus_addr, bus_rwn, bus_wdata, bus_wdata_oe,
    input  done
  );

endinterface

// File: rtl/bus_burst_initiator.sv
// Burst initiator for the Addr/Data/RWn memory bus: one beat at a time, two cycles per beat,
// every bus-facing output comes straight from a flop so RWn cannot glitch.
module bus_burst_initiator #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  bus_burst_initiator_if.master bus
);

  typedef enum logic [2:0] {
    StIdle,
    StWrWait,
    StWrStrobe,
    StRdAddr,
    StRdOut
  } state_e;

  state_e            state_q;
  logic [LEN_W-1:0]  beats_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rwn_q;
  logic              oe_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              done_q;

  // beats_q counts beats still to run after the current one; zero marks the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      beats_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rwn_q      <= 1'b1;
      oe_q       <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.cmd_valid) begin
            addr_q  <= bus.cmd_addr;
            beats_q <= bus.cmd_len;
            state_q <= bus.cmd_rwn ? StRdAddr : StWrWait;
          end
        end
        StWrWait: begin
          if (bus.wr_valid) begin
            wdata_q <= bus.wr_data;
            rwn_q   <= 1'b0;
            oe_q    <= 1'b1;
            state_q <= StWrStrobe;
          end
        end
        StWrStrobe: begin
          // Address and data were set up a cycle earlier and only move after RWn returns high.
          rwn_q <= 1'b1;
          oe_q  <= 1'b0;
          if (beats_q == '0) begin
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else begin
            addr_q  <= addr_q + ADDR_W'(1);
            beats_q <= beats_q - LEN_W'(1);
            state_q <= StWrWait;
          end
        end
        StRdAddr: begin
          rd_data_q  <= bus.bus_rdata;
          rd_valid_q <= 1'b1;
          state_q    <= StRdOut;
        end
        StRdOut: begin
          if (bus.rd_ready) begin
            rd_valid_q <= 1'b0;
            if (beats_q == '0) begin
              done_q  <= 1'b1;
              state_q <= StIdle;
            end else begin
              addr_q  <= addr_q + ADDR_W'(1);
              beats_q <= beats_q - LEN_W'(1);
              state_q <= StRdAddr;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.cmd_ready    = (state_q == StIdle);
  assign bus.wr_ready     = (state_q == StWrWait);
  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.bus_addr     = addr_q;
  assign bus.bus_rwn      = rwn_q;
  assign bus.bus_wdata    = wdata_q;
  assign bus.bus_wdata_oe = oe_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_bus_burst_initiator.sv
// Directed bench for bus_burst_initiator with a small RAM responder on the bus side.
module tb_bus_burst_initiator;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned LEN_W  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  bus_burst_initiator_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus_if ();

  bus_burst_initiator #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  // RAM responder: combinational read, write committed at the edge closing a strobe cycle.
  logic [7:0] mem [256] = '{default: 8'h00};
  assign bus_if.bus_rdata = mem[bus_if.bus_addr];
  always @(posedge clk) if (bus_if.bus_rwn === 1'b0) mem[bus_if.bus_addr] <= bus_if.bus_wdata;

  // Bus monitor: logs every strobe cycle, longest strobe run, done pulses, OE consistency.
  logic [7:0] st_addr [64];
  logic [7:0] st_data [64];
  int st_cnt = 0, st_run = 0, st_max_run = 0, done_cnt = 0, oe_bad = 0;
  always @(negedge clk) begin
    if (bus_if.done === 1'b1) done_cnt <= done_cnt + 1;
    if (bus_if.bus_wdata_oe !== ~bus_if.bus_rwn) oe_bad <= oe_bad + 1;
    if (bus_if.bus_rwn === 1'b0) begin
      if (st_cnt < 64) begin
        st_addr[st_cnt] <= bus_if.bus_addr;
        st_data[st_cnt] <= bus_if.bus_wdata;
      end
      st_cnt <= st_cnt + 1;
      st_run <= st_run + 1;
      if (st_run + 1 > st_max_run) st_max_run <= st_run + 1;
    end else begin
      st_run <= 0;
    end
  end

  task automatic send_cmd(input logic rwn, input logic [7:0] addr, input logic [3:0] len);
    int cnt;
    cnt = 0;
    while (bus_if.cmd_ready !== 1'b1 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    n_checks++;
    if (cnt >= 50) begin
      n_fail++;
      $display("FAIL cmd_ready_wait: cmd_ready=%b required 1", bus_if.cmd_ready);
    end
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_rwn   = rwn;
    bus_if.cmd_addr  = addr;
    bus_if.cmd_len   = len;
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
  endtask

  // Offers beats back-to-back; wr_valid stays high through strobes. Returns in last strobe.
  task automatic feed_write(input logic [31:0] data, input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      int cnt;
      cnt = 0;
      while (bus_if.wr_ready !== 1'b1 && cnt < 50) begin
        @(negedge clk);
        cnt++;
      end
      n_checks++;
      if (cnt >= 50) begin
        n_fail++;
        $display("FAIL wr_ready_wait: wr_ready=%b required 1", bus_if.wr_ready);
      end
      bus_if.wr_valid = 1'b1;
      bus_if.wr_data  = data[8*i +: 8];
      @(negedge clk);
    end
    bus_if.wr_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int cnt;
    cnt = 0;
    while (bus_if.done !== 1'b1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    n_checks++;
    if (cnt >= 100) begin
      n_fail++;
      $display("FAIL %s_done_wait: done=%b required 1", name, bus_if.done);
    end
  endtask

  task automatic test_reset();
    logic [7:0] act [9];
    logic [7:0] exp [9];
    @(negedge clk);
    act = '{8'(bus_if.bus_rwn), 8'(bus_if.bus_wdata_oe), bus_if.bus_addr, bus_if.bus_wdata,
            bus_if.rd_data, 8'(bus_if.rd_valid), 8'(bus_if.wr_ready), 8'(bus_if.done),
            8'(bus_if.cmd_ready)};
    exp = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if (act[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL reset_value[%0d]: got %h required %h", i, act[i], exp[i]);
      end
    end
    rst_n = 1'b1;
    // Stray wr_valid / rd_ready while idle must do nothing.
    bus_if.wr_valid = 1'b1;
    bus_if.rd_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (bus_if.bus_rwn !== 1'b1 || bus_if.rd_valid !== 1'b0 || bus_if.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_ignore: rwn=%b rd_valid=%b cmd_ready=%b required 1 0 1",
               bus_if.bus_rwn, bus_if.rd_valid, bus_if.cmd_ready);
    end
    bus_if.wr_valid = 1'b0;
    bus_if.rd_ready = 1'b0;
  endtask

  task automatic test_write();
    int base, dbase;
    #1;
    base = st_cnt;
    dbase = done_cnt;
    send_cmd(1'b0, 8'h10, 4'd3);
    feed_write(32'hA3A2A1A0, 4);
    wait_done("write");
    n_checks++;
    if (bus_if.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL write_ready_with_done: cmd_ready=%b required 1", bus_if.cmd_ready);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (st_cnt - base !== 4 || st_max_run !== 1 || bus_if.done !== 1'b0) begin
      n_fail++;
      $display("FAIL write_strobes: count=%0d maxrun=%0d done=%b required 4 1 0",
               st_cnt - base, st_max_run, bus_if.done);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (st_addr[base+i] !== 8'h10 + 8'(i) || st_data[base+i] !== 8'hA0 + 8'(i) ||
          mem[8'h10 + 8'(i)] !== 8'hA0 + 8'(i)) begin
        n_fail++;
        $display("FAIL write_beat[%0d]: addr=%h data=%h mem=%h required %h %h %h", i,
                 st_addr[base+i], st_data[base+i], mem[8'h10 + 8'(i)], 8'h10 + 8'(i),
                 8'hA0 + 8'(i), 8'hA0 + 8'(i));
      end
    end
    n_checks++;
    if (done_cnt - dbase !== 1 || oe_bad !== 0) begin
      n_fail++;
      $display("FAIL write_done_oe: done_pulses=%0d oe_bad=%0d required 1 0",
               done_cnt - dbase, oe_bad);
    end
  endtask

  task automatic test_readback();
    logic [7:0] rec [4];
    int got, cnt, base, dbase;
    #1;
    base = st_cnt;
    dbase = done_cnt;
    got = 0;
    cnt = 0;
    bus_if.rd_ready = 1'b1;
    send_cmd(1'b1, 8'h10, 4'd3);
    while (got < 4 && cnt < 100) begin
      if (bus_if.rd_valid === 1'b1) begin
        rec[got] = bus_if.rd_data;
        got++;
      end
      @(negedge clk);
      cnt++;
    end
    n_checks++;
    if (got !== 4 || bus_if.done !== 1'b1) begin
      n_fail++;
      $display("FAIL read_count_done: beats=%0d done=%b required 4 1", got, bus_if.done);
    end
    bus_if.rd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rec[i] !== 8'hA0 + 8'(i)) begin
        n_fail++;
        $display("FAIL read_data[%0d]: got %h required %h", i, rec[i], 8'hA0 + 8'(i));
      end
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (st_cnt !== base || done_cnt - dbase !== 1) begin
      n_fail++;
      $display("FAIL read_no_strobe: strobes=%0d done_pulses=%0d required 0 1",
               st_cnt - base, done_cnt - dbase);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_a [4];
    int base;
    exp_a = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    #1;
    base = st_cnt;
    send_cmd(1'b0, 8'hFE, 4'd3);
    feed_write(32'h44332211, 4);
    wait_done("wrap");
    @(negedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (st_addr[base+i] !== exp_a[i] || mem[exp_a[i]] !== 8'h11 * 8'(i + 1)) begin
        n_fail++;
        $display("FAIL wrap_beat[%0d]: addr=%h mem=%h required %h %h", i, st_addr[base+i],
                 mem[exp_a[i]], exp_a[i], 8'h11 * 8'(i + 1));
      end
    end
  endtask

  task automatic test_backpressure();
    int cnt;
    cnt = 0;
    bus_if.rd_ready = 1'b0;
    send_cmd(1'b1, 8'h10, 4'd1);
    while (bus_if.rd_valid !== 1'b1 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (bus_if.rd_valid !== 1'b1 || bus_if.rd_data !== 8'hA0 || bus_if.bus_addr !== 8'h10) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: rd_valid=%b rd_data=%h addr=%h required 1 a0 10", k,
                 bus_if.rd_valid, bus_if.rd_data, bus_if.bus_addr);
      end
      if (k < 4) @(negedge clk);
    end
    bus_if.rd_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus_if.rd_valid !== 1'b0 || bus_if.bus_addr !== 8'h11) begin
      n_fail++;
      $display("FAIL stall_release: rd_valid=%b addr=%h required 0 11", bus_if.rd_valid,
               bus_if.bus_addr);
    end
    @(negedge clk);
    n_checks++;
    if (bus_if.rd_valid !== 1'b1 || bus_if.rd_data !== 8'hA1) begin
      n_fail++;
      $display("FAIL stall_beat1: rd_valid=%b rd_data=%h required 1 a1", bus_if.rd_valid,
               bus_if.rd_data);
    end
    @(negedge clk);
    n_checks++;
    if (bus_if.done !== 1'b1 || bus_if.rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_done: done=%b rd_valid=%b required 1 0", bus_if.done, bus_if.rd_valid);
    end
    bus_if.rd_ready = 1'b0;
  endtask

  task automatic test_busy();
    int base;
    #1;
    base = st_cnt;
    send_cmd(1'b0, 8'h20, 4'd1);
    // Offer a read command for the whole write burst; it must wait for IDLE.
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_rwn   = 1'b1;
    bus_if.cmd_addr  = 8'h12;
    bus_if.cmd_len   = 4'd0;
    n_checks++;
    if (bus_if.cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_ready: cmd_ready=%b required 0", bus_if.cmd_ready);
    end
    feed_write(32'h00005B5A, 2);
    n_checks++;
    if (bus_if.cmd_ready !== 1'b0 || bus_if.bus_addr !== 8'h21) begin
      n_fail++;
      $display("FAIL busy_ignore: cmd_ready=%b addr=%h required 0 21", bus_if.cmd_ready,
               bus_if.bus_addr);
    end
    @(negedge clk);
    n_checks++;
    if (bus_if.done !== 1'b1 || bus_if.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_done_accept: done=%b cmd_ready=%b required 1 1", bus_if.done,
               bus_if.cmd_ready);
    end
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    n_checks++;
    if (bus_if.cmd_ready !== 1'b0 || bus_if.bus_addr !== 8'h12 || bus_if.bus_rwn !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_next_cmd: cmd_ready=%b addr=%h rwn=%b required 0 12 1",
               bus_if.cmd_ready, bus_if.bus_addr, bus_if.bus_rwn);
    end
    bus_if.rd_ready = 1'b1;
    wait_done("busy_read");
    bus_if.rd_ready = 1'b0;
    n_checks++;
    if (bus_if.rd_data !== 8'hA2) begin
      n_fail++;
      $display("FAIL busy_read_data: got %h required a2", bus_if.rd_data);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (st_cnt - base !== 2 || st_addr[base] !== 8'h20 || st_addr[base+1] !== 8'h21 ||
        mem[8'h20] !== 8'h5A || mem[8'h21] !== 8'h5B) begin
      n_fail++;
      $display("FAIL busy_strobes: count=%0d a0=%h a1=%h m20=%h m21=%h required 2 20 21 5a 5b",
               st_cnt - base, st_addr[base], st_addr[base+1], mem[8'h20], mem[8'h21]);
    end
  endtask

  task automatic test_reset_abort();
    logic [7:0] act [8];
    logic [7:0] exp [8];
    int dbase;
    #1;
    dbase = done_cnt;
    send_cmd(1'b0, 8'h60, 4'd3);
    feed_write(32'hD3D2D1D0, 3);
    n_checks++;
    if (bus_if.bus_rwn !== 1'b0 || bus_if.bus_addr !== 8'h62) begin
      n_fail++;
      $display("FAIL abort_in_strobe: rwn=%b addr=%h required 0 62", bus_if.bus_rwn,
               bus_if.bus_addr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    act = '{8'(bus_if.bus_rwn), 8'(bus_if.bus_wdata_oe), bus_if.bus_addr, bus_if.bus_wdata,
            8'(bus_if.rd_valid), 8'(bus_if.wr_ready), 8'(bus_if.done), 8'(bus_if.cmd_ready)};
    exp = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (act[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL abort_value[%0d]: got %h required %h", i, act[i], exp[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (mem[8'h60] !== 8'hD0 || mem[8'h61] !== 8'hD1 || mem[8'h62] !== 8'h00 ||
        mem[8'h63] !== 8'h00) begin
      n_fail++;
      $display("FAIL abort_ram: %h %h %h %h required d0 d1 00 00", mem[8'h60], mem[8'h61],
               mem[8'h62], mem[8'h63]);
    end
    n_checks++;
    if (done_cnt !== dbase || bus_if.cmd_ready !== 1'b1 || bus_if.bus_rwn !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_no_done: done_pulses=%0d cmd_ready=%b rwn=%b required 0 1 1",
               done_cnt - dbase, bus_if.cmd_ready, bus_if.bus_rwn);
    end
  endtask

  initial begin
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_rwn   = 1'b0;
    bus_if.cmd_addr  = '0;
    bus_if.cmd_len   = '0;
    bus_if.wr_valid  = 1'b0;
    bus_if.wr_data   = '0;
    bus_if.rd_ready  = 1'b0;
    test_reset();
    test_write();
    test_readback();
    test_wrap();
    test_backpressure();
    test_busy();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
